hazard_pipe_ctrl: RTL and testbench

- Decode/execute pipeline-control block on the datapath side of the `controller` interface.
- Each cycle it packs the `datapath_contents` word (decode instruction plus execute-stage opcode/rd) that `controller` reads.
- It takes back `controller`'s `hazard_controls` and produces forwarding selects, fetch stall, bubble insertion and branch/jump flush.
- It holds the execute and writeback instruction slots and a small flush state machine.

---
 rtl/hazard_pipe_ctrl_pkg.sv | 49 ++++
 rtl/hazard_pipe_ctrl.sv | 130 +++++++++++++
 tb/tb_hazard_pipe_ctrl.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/hazard_pipe_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : hazard_pipe_ctrl_pkg
//  Description : Shared constants for the decode/execute pipeline control:
//                RV32 base opcodes, the canonical NOP, forwarding select
//                encodings, flush FSM state type and the is_reg_write()
//                helper used by execute/writeback logic.
//  Revision    : 1.0  initial release
// ============================================================================
package hazard_pipe_ctrl_pkg;

    // RV32I base opcodes (instruction bits [6:0])
    localparam logic [6:0] c_OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] c_OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] c_OP_LOAD   = 7'b0000011;
    localparam logic [6:0] c_OP_STORE  = 7'b0100011;
    localparam logic [6:0] c_OP_BRANCH = 7'b1100011;
    localparam logic [6:0] c_OP_JAL    = 7'b1101111;
    localparam logic [6:0] c_OP_JALR   = 7'b1100111;
    localparam logic [6:0] c_OP_LUI    = 7'b0110111;
    localparam logic [6:0] c_OP_AUIPC  = 7'b0010111;

    // addi x0, x0, 0
    localparam logic [31:0] c_NOP_INST = 32'h0000_0013;

    // Operand source selects
    localparam logic [1:0] c_FWD_REGFILE = 2'b00;
    localparam logic [1:0] c_FWD_EX      = 2'b01;
    localparam logic [1:0] c_FWD_WB      = 2'b10;

    typedef enum logic [0:0] {
        ST_RUN   = 1'b0,
        ST_FLUSH = 1'b1
    } flush_state_t;

    // True for every opcode that writes a destination register.
    function automatic logic is_reg_write(input logic [6:0] opcode);
        logic w;
        w = 1'b0;
        case (opcode)
            c_OP_RTYPE, c_OP_ITYPE, c_OP_LOAD, c_OP_JAL,
            c_OP_JALR, c_OP_LUI, c_OP_AUIPC: w = 1'b1;
            default:                         w = 1'b0;
        endcase
        return w;
    endfunction

endpackage
`default_nettype wire

// File: rtl/hazard_pipe_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : hazard_pipe_ctrl
//  Description : Decode/execute pipeline control on the datapath side of the
//                controller. Packs datapath_contents for the controller,
//                turns its hazard_controls into forwarding selects, fetch
//                stall and execute bubble, and squashes wrong-path fetch
//                words after a redirect with a small flush FSM.
//  Ports       : clk, rst_n (sync, active-low)
//                inst_d            - instruction from fetch/IMEM
//                redirect          - taken branch/jump resolved in execute
//                hazard_controls   - {DhazRs1, DhazRs2, LHazRs1, LHazRs2, LHazEn}
//                datapath_contents - {20'b0, ex rd, ex opcode, decode inst}
//                fwd_a_sel/b_sel   - 00 regfile, 01 execute, 10 writeback
//                stall_f           - hold PC / IMEM output register
//                bubble_x          - load NOP into execute at next edge
//  Revision    : 1.0  initial release
// ============================================================================
module hazard_pipe_ctrl
    import hazard_pipe_ctrl_pkg::*;
#(
    parameter int FLUSH_DEPTH = 1   // legal 1..3, equals IMEM read latency
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] inst_d,
    input  logic        redirect,
    input  logic [4:0]  hazard_controls,
    output logic [63:0] datapath_contents,
    output logic [1:0]  fwd_a_sel,
    output logic [1:0]  fwd_b_sel,
    output logic        stall_f,
    output logic        bubble_x
);

    localparam int                 c_CNT_W    = $clog2(FLUSH_DEPTH + 1);
    localparam logic [c_CNT_W-1:0] c_CNT_LOAD = c_CNT_W'(FLUSH_DEPTH);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);

    flush_state_t       r_state;
    logic [c_CNT_W-1:0] r_cnt;
    logic [31:0]        r_ex_q;
    logic [4:0]         r_wb_rd;
    logic               r_wb_we;

    logic [31:0]        w_inst_e;
    logic               w_lhaz_en;
    logic               w_wb_valid;

    // Only the load-use enable matters here; the per-operand load flags
    // are informational and the upper execute bits are not forwarded.
    logic w_unused_ok;
    assign w_unused_ok = &{1'b0, hazard_controls[2:1], r_ex_q[31:12]};

    // ------------------------------------------------------------------
    // Combinational outputs
    // ------------------------------------------------------------------
    always_comb begin
        w_inst_e   = (r_state == ST_FLUSH) ? c_NOP_INST : inst_d;
        w_lhaz_en  = hazard_controls[0];
        w_wb_valid = r_wb_we && (r_wb_rd != 5'd0);

        datapath_contents = {20'b0, r_ex_q[11:7], r_ex_q[6:0], w_inst_e};

        // Redirect wins: the fetch-side squash is handled by FLUSH, so
        // stalling fetch on the same cycle would only lose a slot.
        stall_f  = w_lhaz_en && !redirect;
        bubble_x = w_lhaz_en || redirect;

        // Execute-stage match has priority over writeback match.
        if (hazard_controls[4]) begin
            fwd_a_sel = c_FWD_EX;
        end else if (w_wb_valid && (w_inst_e[19:15] == r_wb_rd)) begin
            fwd_a_sel = c_FWD_WB;
        end else begin
            fwd_a_sel = c_FWD_REGFILE;
        end

        if (hazard_controls[3]) begin
            fwd_b_sel = c_FWD_EX;
        end else if (w_wb_valid && (w_inst_e[24:20] == r_wb_rd)) begin
            fwd_b_sel = c_FWD_WB;
        end else begin
            fwd_b_sel = c_FWD_REGFILE;
        end
    end

    // ------------------------------------------------------------------
    // Slots and flush FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_RUN;
            r_cnt   <= '0;
            r_ex_q  <= c_NOP_INST;
            r_wb_rd <= 5'd0;
            r_wb_we <= 1'b0;
        end else begin
            r_ex_q  <= bubble_x ? c_NOP_INST : w_inst_e;
            r_wb_rd <= r_ex_q[11:7];
            r_wb_we <= is_reg_write(r_ex_q[6:0]);

            case (r_state)
                ST_RUN: begin
                    if (redirect) begin
                        r_state <= ST_FLUSH;
                        r_cnt   <= c_CNT_LOAD;
                    end
                end
                ST_FLUSH: begin
                    // A redirect during the window restarts the squash.
                    if (redirect) begin
                        r_cnt <= c_CNT_LOAD;
                    end else if (r_cnt == c_CNT_ONE) begin
                        r_state <= ST_RUN;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt - c_CNT_ONE;
                    end
                end
                default: begin
                    r_state <= ST_RUN;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_hazard_pipe_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_hazard_pipe_ctrl
//  Description : Scoreboard bench for hazard_pipe_ctrl. A driver applies
//                directed then random stimulus, evaluates a history-based
//                reference model and queues the expected outputs; a monitor
//                on the falling edge pops and compares them.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_hazard_pipe_ctrl;

    localparam int          FD  = 2;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] inst_d = 32'h0;
    logic        redirect = 1'b0;
    logic [4:0]  hc = 5'h0;
    logic [63:0] datapath_contents;
    logic [1:0]  fwd_a_sel, fwd_b_sel;
    logic        stall_f, bubble_x;

    hazard_pipe_ctrl #(.FLUSH_DEPTH(FD)) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .inst_d            (inst_d),
        .redirect          (redirect),
        .hazard_controls   (hc),
        .datapath_contents (datapath_contents),
        .fwd_a_sel         (fwd_a_sel),
        .fwd_b_sel         (fwd_b_sel),
        .stall_f           (stall_f),
        .bubble_x          (bubble_x)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] dc;
        logic [1:0]  fa;
        logic [1:0]  fb;
        logic        st;
        logic        bx;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    // ---------------- reference model ----------------
    // hist holds {valid, instruction} for the instructions that entered
    // execute, oldest first: [0] is now in writeback, [1] in execute.
    logic [32:0] hist[$];
    int          squash_left;
    logic        p_rst_n = 1'b0;
    logic        p_redir = 1'b0;
    logic        p_bx    = 1'b0;
    logic [31:0] p_dec   = NOP;

    function automatic bit writes_rd(input logic [6:0] op);
        return (op == 7'h33) || (op == 7'h13) || (op == 7'h03) ||
               (op == 7'h6F) || (op == 7'h67) || (op == 7'h37) ||
               (op == 7'h17);
    endfunction

    function automatic logic [31:0] enc_r(input logic [4:0] rd, rs1, rs2);
        return {7'b0, rs2, rs1, 3'b000, rd, 7'b0110011};
    endfunction

    function automatic logic [31:0] enc_i(input logic [6:0] op, input logic [4:0] rd,
                                          input logic [4:0] rs1, input logic [2:0] f3,
                                          input logic [11:0] imm);
        return {imm, rs1, f3, rd, op};
    endfunction

    function automatic logic [31:0] rand_inst();
        logic [6:0] ops [10];
        logic [31:0] w;
        ops = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6F, 7'h67, 7'h37, 7'h17, 7'h7F};
        w = $urandom;
        w[6:0]   = ops[$urandom_range(0, 9)];
        w[11:7]  = 5'($urandom_range(0, 3));
        w[19:15] = 5'($urandom_range(0, 3));
        w[24:20] = 5'($urandom_range(0, 3));
        return w;
    endfunction

    task automatic model_reset();
        hist.delete();
        hist.push_back({1'b0, NOP});
        hist.push_back({1'b1, NOP});
        squash_left = 0;
    endtask

    task automatic model_edge();
        if (!p_rst_n) begin
            model_reset();
        end else begin
            hist.push_back({1'b1, p_bx ? NOP : p_dec});
            while (hist.size() > 2) void'(hist.pop_front());
            if (p_redir)              squash_left = FD;
            else if (squash_left > 0) squash_left = squash_left - 1;
        end
    endtask

    task automatic step(input logic r, input logic [31:0] i, input logic rd,
                        input logic [4:0] h);
        exp_t        e;
        logic [32:0] wbe;
        logic [31:0] ex, dec, wbi;
        bit          wb_ok;
        @(posedge clk);
        model_edge();
        #1;
        rst_n = r; inst_d = i; redirect = rd; hc = h;
        wbe   = hist[0];
        wbi   = wbe[31:0];
        ex    = hist[1][31:0];
        dec   = (squash_left > 0) ? NOP : i;
        wb_ok = wbe[32] && writes_rd(wbi[6:0]) && (wbi[11:7] != 5'd0);
        e.dc  = {20'b0, ex[11:7], ex[6:0], dec};
        e.st  = h[0] && !rd;
        e.bx  = h[0] || rd;
        e.fa  = h[4] ? 2'b01 : (wb_ok && dec[19:15] == wbi[11:7]) ? 2'b10 : 2'b00;
        e.fb  = h[3] ? 2'b01 : (wb_ok && dec[24:20] == wbi[11:7]) ? 2'b10 : 2'b00;
        sb.push_back(e);
        p_rst_n = r; p_redir = rd; p_bx = e.bx; p_dec = dec;
    endtask

    // ---------------- monitor ----------------
    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("datapath_contents", datapath_contents, e.dc);
            chk("fwd_a_sel", 64'(fwd_a_sel), 64'(e.fa));
            chk("fwd_b_sel", 64'(fwd_b_sel), 64'(e.fb));
            chk("stall_f",   64'(stall_f),   64'(e.st));
            chk("bubble_x",  64'(bubble_x),  64'(e.bx));
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        model_reset();

        // reset with random fetch data
        for (int k = 0; k < 3; k++) step(1'b0, $urandom, 1'b0, 5'h00);

        // execute-stage forwarding on rs1
        step(1'b1, enc_r(5'd5, 5'd1, 5'd2), 1'b0, 5'h00);
        step(1'b1, enc_r(5'd6, 5'd5, 5'd3), 1'b0, 5'b10000);

        // load-use: stall cycle, then writeback forwarding on both operands
        step(1'b1, enc_i(7'h03, 5'd5, 5'd1, 3'b010, 12'd0), 1'b0, 5'h00);
        step(1'b1, enc_r(5'd6, 5'd5, 5'd5), 1'b0, 5'b00111);
        step(1'b1, enc_r(5'd6, 5'd5, 5'd5), 1'b0, 5'h00);

        // write to x0 is never forwarded
        step(1'b1, enc_i(7'h13, 5'd0, 5'd0, 3'b000, 12'd1), 1'b0, 5'h00);
        step(1'b1, NOP, 1'b0, 5'h00);
        step(1'b1, enc_r(5'd7, 5'd0, 5'd0), 1'b0, 5'h00);

        // single redirect: two squashed words then pass-through
        step(1'b1, $urandom, 1'b1, 5'h00);
        step(1'b1, $urandom, 1'b0, 5'h00);
        step(1'b1, $urandom, 1'b0, 5'h00);
        step(1'b1, enc_r(5'd1, 5'd2, 5'd3), 1'b0, 5'h00);

        // second redirect inside the window extends the squash
        step(1'b1, $urandom, 1'b1, 5'h00);
        step(1'b1, $urandom, 1'b1, 5'h00);
        step(1'b1, $urandom, 1'b0, 5'h00);
        step(1'b1, $urandom, 1'b0, 5'h00);
        step(1'b1, enc_r(5'd2, 5'd1, 5'd1), 1'b0, 5'h00);

        // redirect beats load stall, then reset mid-flush
        step(1'b1, $urandom, 1'b1, 5'b00001);
        step(1'b0, $urandom, 1'b0, 5'h00);
        step(1'b1, enc_r(5'd3, 5'd1, 5'd2), 1'b0, 5'h00);
        step(1'b1, enc_r(5'd4, 5'd3, 5'd3), 1'b0, 5'h00);

        // randomized traffic
        for (int k = 0; k < 500; k++) begin
            logic [4:0] h;
            h      = 5'($urandom);
            h[0]   = ($urandom_range(0, 5) == 0);
            step(($urandom_range(0, 60) != 0), rand_inst(),
                 ($urandom_range(0, 9) == 0), h);
        end

        @(negedge clk);
        #1;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain actual=%0d required=0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
